// File: rtl/rx_rr_arbiter_pkg.sv
// Shared constants and helpers for the rx round-robin arbiter.
// Port index order matches the router's direction numbering (N, S, E, W, L).
package rx_rr_arbiter_pkg;
  localparam int SIZE       = 8;
  localparam int DIRECTIONS = 5;
  localparam int PTR_W      = 3;
  localparam int HOLD_DEF   = 3;

  localparam logic [PTR_W-1:0] DIR_N = 3'd0;
  localparam logic [PTR_W-1:0] DIR_S = 3'd1;
  localparam logic [PTR_W-1:0] DIR_E = 3'd2;
  localparam logic [PTR_W-1:0] DIR_W = 3'd3;
  localparam logic [PTR_W-1:0] DIR_L = 3'd4;

  function automatic logic [2:0] popcount_ports(input logic [DIRECTIONS-1:0] v);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < DIRECTIONS; i++) begin
      n = n + {2'b00, v[i]};
    end
    return n;
  endfunction
endpackage

// File: rtl/rx_rr_arbiter_rr_pick.sv
// Combinational rotate-priority encoder: first set request after ptr, wrapping mod PORTS.
module rr_pick
  import rx_rr_arbiter_pkg::*;
#(
  parameter int PORTS = DIRECTIONS
) (
  input  logic [PORTS-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [PORTS-1:0] gnt_onehot,
  output logic [PTR_W-1:0] gnt_idx,
  output logic             any
);
  always_comb begin
    int idx;
    gnt_onehot = '0;
    gnt_idx    = '0;
    any        = 1'b0;
    idx        = 0;
    for (int i = 1; i <= PORTS; i++) begin
      idx = (int'(ptr) + i) % PORTS;
      if (!any && req[idx]) begin
        any             = 1'b1;
        gnt_onehot[idx] = 1'b1;
        gnt_idx         = PTR_W'(idx);
      end
    end
  end
endmodule

// File: rtl/rx_rr_arbiter.sv
// Round-robin arbiter sharing the FIFO write port among the rx deserialisers,
// with a one-entry output register and per-port decaying activity counters.
module rx_rr_arbiter
  import rx_rr_arbiter_pkg::*;
#(
  parameter int ITEM_W = SIZE,
  parameter int PORTS  = DIRECTIONS,
  parameter int HOLD   = HOLD_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [PORTS-1:0]        valid,
  input  logic [PORTS*ITEM_W-1:0] items_in,
  output logic [PORTS-1:0]        item_read,
  input  logic                    full,
  output logic [ITEM_W-1:0]       item_out,
  output logic                    write,
  output logic [2:0]              grant_id,
  output logic [2:0]              activity_level
);
  logic              r_out_valid;
  logic [ITEM_W-1:0] r_item;
  logic [2:0]        r_gid;
  logic [PTR_W-1:0]  r_ptr;
  logic [2:0]        r_level;
  logic [1:0]        r_cnt [PORTS];

  logic              w_accept;
  logic              w_any;
  logic              w_grant;
  logic [PORTS-1:0]  w_onehot;
  logic [PTR_W-1:0]  w_idx;
  logic [PORTS-1:0]  w_active;

  // The register can take a new item when empty or when its item leaves at this edge.
  assign w_accept = !r_out_valid || !full;

  rr_pick #(.PORTS(PORTS)) u_pick (
    .req        (valid),
    .ptr        (r_ptr),
    .gnt_onehot (w_onehot),
    .gnt_idx    (w_idx),
    .any        (w_any)
  );

  assign w_grant   = w_accept && w_any && !reset;
  assign item_read = w_grant ? w_onehot : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_item      <= '0;
      r_gid       <= '0;
      r_ptr       <= DIR_L;
    end else if (w_grant) begin
      r_item      <= items_in[int'(w_idx)*ITEM_W +: ITEM_W];
      r_gid       <= w_idx;
      r_out_valid <= 1'b1;
      r_ptr       <= w_idx;
    end else if (w_accept) begin
      r_out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    for (int p = 0; p < PORTS; p++) begin
      if (reset) begin
        r_cnt[p] <= '0;
      end else if (w_grant && w_onehot[p]) begin
        r_cnt[p] <= 2'(HOLD);
      end else if (r_cnt[p] != 2'd0) begin
        r_cnt[p] <= r_cnt[p] - 2'd1;
      end
    end
  end

  always_comb begin
    w_active = '0;
    for (int p = 0; p < PORTS; p++) begin
      w_active[p] = (r_cnt[p] != 2'd0);
    end
  end

  // Level lags the counters by one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_level <= '0;
    end else begin
      r_level <= popcount_ports(w_active);
    end
  end

  assign item_out       = r_item;
  assign write          = r_out_valid;
  assign grant_id       = r_gid;
  assign activity_level = r_level;
endmodule

// File: tb/tb_rx_rr_arbiter.sv
// Scoreboard bench for rx_rr_arbiter: directed scenarios then randomized traffic.
module tb_rx_rr_arbiter;
  localparam int IW = 8;
  localparam int NP = 5;
  localparam int HOLDV = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic [NP-1:0]     valid;
  logic [NP*IW-1:0]  items_in;
  logic [NP-1:0]     item_read;
  logic              full;
  logic [IW-1:0]     item_out;
  logic              write;
  logic [2:0]        grant_id;
  logic [2:0]        activity_level;

  rx_rr_arbiter #(.ITEM_W(IW), .PORTS(NP), .HOLD(HOLDV)) dut (
    .clk            (clk),
    .reset          (reset),
    .valid          (valid),
    .items_in       (items_in),
    .item_read      (item_read),
    .full           (full),
    .item_out       (item_out),
    .write          (write),
    .grant_id       (grant_id),
    .activity_level (activity_level)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [IW-1:0] item;
    int            id;
  } exp_t;

  exp_t          q[$];
  int            errors = 0;
  int            checks = 0;
  bit            mon_en = 0;

  logic [IW-1:0] it_cur [NP];
  int            last_g = 4;
  int            cnt [NP];
  int            level = 0;
  int            pend_g = -1;
  logic [IW-1:0] pend_item = '0;
  bit            pend_reset = 1;
  logic [NP-1:0] rx_pend = '0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic int model_pick(input logic [NP-1:0] v);
    for (int i = 1; i <= NP; i++) begin
      if (v[(last_g + i) % NP]) return (last_g + i) % NP;
    end
    return -1;
  endfunction

  // Advance the reference model across one clock edge.
  task automatic model_edge();
    int active;
    if (pend_reset) begin
      q.delete();
      last_g = 4;
      level  = 0;
      for (int p = 0; p < NP; p++) cnt[p] = 0;
    end else begin
      active = 0;
      for (int p = 0; p < NP; p++) if (cnt[p] != 0) active++;
      level = active;
      for (int p = 0; p < NP; p++) begin
        if (p == pend_g) cnt[p] = HOLDV;
        else if (cnt[p] > 0) cnt[p] = cnt[p] - 1;
      end
      if (pend_g >= 0) begin
        exp_t e;
        e.item = pend_item;
        e.id   = pend_g;
        q.push_back(e);
        last_g = pend_g;
      end
    end
  endtask

  task automatic step(input logic [NP-1:0] v, input logic f, input logic r);
    int g;
    bit was_reset;
    bit acc;
    logic [NP-1:0] exp_rd;
    @(posedge clk);
    was_reset = pend_reset;
    model_edge();
    #2;
    valid = v;
    full  = f;
    reset = r;
    for (int p = 0; p < NP; p++) items_in[p*IW +: IW] = it_cur[p];
    #1;
    if (was_reset) begin
      check("reset_write", int'(write), 0);
      check("reset_item_out", int'(item_out), 0);
      check("reset_grant_id", int'(grant_id), 0);
    end
    acc = (q.size() == 0) || !f;
    g = (acc && !r) ? model_pick(v) : -1;
    exp_rd = '0;
    if (g >= 0) exp_rd[g] = 1'b1;
    check("item_read", int'(item_read), int'(exp_rd));
    check("activity_level", int'(activity_level), level);
    pend_g     = g;
    pend_item  = (g >= 0) ? it_cur[g] : '0;
    pend_reset = r;
  endtask

  task automatic rand_items();
    for (int p = 0; p < NP; p++) it_cur[p] = IW'($urandom);
  endtask

  // Monitor: compares the held item against the scoreboard, pops on consume.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        check("write_vs_model", int'(write), int'(q.size() > 0));
        if (write === 1'b1 && q.size() > 0) begin
          check("item_out", int'(item_out), int'(q[0].item));
          check("grant_id", int'(grant_id), q[0].id);
          if (!full && !reset) void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    valid = '0;
    full  = 1'b0;
    items_in = '0;
    for (int p = 0; p < NP; p++) begin
      it_cur[p] = '0;
      cnt[p] = 0;
    end
    step('0, 0, 1);
    step('0, 0, 1);
    mon_en = 1;

    // 1: lone N request
    rand_items(); it_cur[0] = 8'hA5;
    step(5'b00001, 0, 0);
    for (int i = 0; i < 3; i++) begin rand_items(); step('0, 0, 0); end

    // 2: all ports continuously
    for (int i = 0; i < 10; i++) begin rand_items(); step(5'b11111, 0, 0); end
    step('0, 0, 0);

    // 3: held item under full while E waits
    rand_items(); step(5'b00001, 0, 0);
    for (int i = 0; i < 5; i++) begin rand_items(); step(5'b00100, 1, 0); end
    rand_items(); step(5'b00100, 0, 0);
    for (int i = 0; i < 2; i++) begin rand_items(); step('0, 0, 0); end

    // 4: reset while holding under full
    rand_items(); step(5'b00010, 0, 0);
    step('0, 1, 0);
    step('0, 1, 1);
    for (int i = 0; i < 3; i++) begin rand_items(); step(5'b11111, 0, 0); end
    step('0, 0, 0);
    for (int i = 0; i < 5; i++) step('0, 0, 0);

    // 5: single W grant, then silence
    rand_items(); step(5'b01000, 0, 0);
    for (int i = 0; i < 7; i++) step('0, 0, 0);

    // 6: only L
    for (int i = 0; i < 8; i++) begin rand_items(); step(5'b10000, 0, 0); end
    step('0, 0, 0);

    // Randomized rx traffic: each port holds valid until acknowledged.
    rx_pend = '0;
    for (int i = 0; i < 600; i++) begin
      logic rst_now;
      rst_now = ($urandom_range(0, 99) == 0);
      for (int p = 0; p < NP; p++) begin
        if (pend_g == p) rx_pend[p] = 1'b0;
        else if (!rx_pend[p] && $urandom_range(0, 2) == 0) begin
          rx_pend[p] = 1'b1;
          it_cur[p] = IW'($urandom);
        end
      end
      if (pend_g >= 0 && !rx_pend[pend_g] && $urandom_range(0, 2) == 0) begin
        rx_pend[pend_g] = 1'b1;
        it_cur[pend_g] = IW'($urandom);
      end
      step(rx_pend, ($urandom_range(0, 3) == 0), rst_now);
    end
    step('0, 0, 0);
    step('0, 0, 0);
    step('0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
